// File: rtl/mux_8to1_rr_if.sv
// ---------------------------------------------------------------------------
// mux_8to1_rr_if
// Bundles the eight valid/ready source channels and the single tagged output
// stream of the round-robin multiplexer.
//
// Signals:
//   in_data   [8*WIDTH] channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid  [8]       per-channel valid
//   in_ready  [8]       per-channel ready (one-hot or zero)
//   out_data  [WIDTH]   output word
//   out_sel   [3]       channel tag of out_data
//   out_valid           output valid
//   out_ready           downstream ready
//   chan_mask [8]       per-channel disable (only with MUX_CHAN_MASK_EN)
//
// Modports: slave = the multiplexer, master = sources plus downstream sink.
// Optional feature macro: MUX_CHAN_MASK_EN
// ---------------------------------------------------------------------------
interface mux_8to1_rr_if #(
    parameter int WIDTH = 8
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX_CHAN_MASK_EN
    logic [7:0]         chan_mask;
`endif

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid,
        input  out_ready
`ifdef MUX_CHAN_MASK_EN
        ,
        input  chan_mask
`endif
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid,
        output out_ready
`ifdef MUX_CHAN_MASK_EN
        ,
        output chan_mask
`endif
    );
endinterface

// File: rtl/mux_8to1_rr.sv
// ---------------------------------------------------------------------------
// mux_8to1_rr
// 8-channel round-robin time-division multiplexer. Accepts at most one word
// per cycle from eight valid/ready sources and presents it, tagged with its
// channel number, in a single-entry registered output stage. The tag drives
// the select of the far-end 1-to-8 demux.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_8to1_rr_if.slave (in_data/in_valid/in_ready,
//          out_data/out_sel/out_valid/out_ready, optional chan_mask)
//
// Optional feature macro: MUX_CHAN_MASK_EN adds chan_mask; a masked channel
// is never eligible for a grant.
// ---------------------------------------------------------------------------
module mux_8to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_8to1_rr_if.slave      bus
);

    logic [WIDTH-1:0] w_ch_data [8];
    logic [7:0]       w_elig;
    logic             w_load;
    logic             w_found;
    logic [2:0]       w_gnt;
    logic             w_xfer;

    logic [2:0]       r_ptr;
    logic             r_run;
    logic [WIDTH-1:0] r_out_data_p1;
    logic [2:0]       r_out_sel_p1;
    logic             r_vld_p1;

    for (genvar k = 0; k < 8; k++) begin : g_split
        assign w_ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

`ifdef MUX_CHAN_MASK_EN
    assign w_elig = bus.in_valid & ~bus.chan_mask;
`else
    assign w_elig = bus.in_valid;
`endif

    assign w_load = !r_vld_p1 || bus.out_ready;

    // Circular priority search starting at the round-robin pointer.
    always_comb begin
        logic [2:0] idx;
        w_found = 1'b0;
        w_gnt   = 3'd0;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = r_ptr + 3'(i);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_gnt   = idx;
            end
        end
    end

    // r_run is cleared asynchronously by reset and set on the first edge
    // after release, so no ready is offered until that edge.
    assign w_xfer       = w_found && w_load && r_run;
    assign bus.in_ready = w_xfer ? (8'b1 << w_gnt) : 8'h00;

    // ---- stage p1: registered output word, tag and valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_ptr         <= 3'd0;
            r_vld_p1      <= 1'b0;
            r_out_data_p1 <= '0;
            r_out_sel_p1  <= 3'd0;
        end else begin
            r_run <= 1'b1;
            if (w_xfer) begin
                r_out_data_p1 <= w_ch_data[w_gnt];
                r_out_sel_p1  <= w_gnt;
                r_vld_p1      <= 1'b1;
                r_ptr         <= w_gnt + 3'd1;
            end else if (w_load) begin
                // Word consumed (or none held) and nothing granted: data and
                // tag keep their last values, only valid drops.
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data_p1;
    assign bus.out_sel   = r_out_sel_p1;
    assign bus.out_valid = r_vld_p1;

endmodule

// File: tb/tb_mux_8to1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_8to1_rr
// Directed bench for mux_8to1_rr: reset, single channel, round-robin order,
// backpressure, pointer wrap and idle, and (with MUX_CHAN_MASK_EN) masking.
// ---------------------------------------------------------------------------
module tb_mux_8to1_rr;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_8to1_rr_if #(.WIDTH(WIDTH)) bus ();

    mux_8to1_rr #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        bus.in_data[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] s, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_sel"},   32'(bus.out_sel),   32'(s));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 8'h00;
        bus.out_ready = 1'b0;
`ifdef MUX_CHAN_MASK_EN
        bus.chan_mask = 8'h00;
`endif
        #2;
        chk_out("rst", 1'b0, 3'd0, 8'h00);
        chk("rst_rdy", 32'(bus.in_ready), 32'h00);
        tick();
        tick();

        // Single channel 5 (ptr goes 0 -> 6)
        rst_n = 1'b1;
        set_ch(5, 8'hA5);
        bus.in_valid  = 8'h20;
        bus.out_ready = 1'b1;
        #1;
        chk("no_rdy_before_edge", 32'(bus.in_ready), 32'h00);
        tick();
        chk("single_rdy", 32'(bus.in_ready), 32'h20);
        tick();
        chk_out("single", 1'b1, 3'd5, 8'hA5);
        bus.in_valid = 8'h00;
        tick();
        chk_out("single_drain", 1'b0, 3'd5, 8'hA5);

        // Reset mid-stream with a held word
        set_ch(3, 8'h33);
        bus.in_valid = 8'h08;
        tick();
        chk_out("pre_rst", 1'b1, 3'd3, 8'h33);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 3'd0, 8'h00);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'h00);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) set_ch(k, 8'(8'h10 + k));
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        chk("rel_no_rdy", 32'(bus.in_ready), 32'h00);
        tick();
        chk("rel_first_rdy", 32'(bus.in_ready), 32'h01);

        // Round robin, all valid: 0..7,0 with no bubbles
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, 3'(i % 8), 8'(8'h10 + (i % 8)));
        end

        // Backpressure on channel 2 (ptr currently 1)
        tick();
        tick();
        chk_out("bp_start", 1'b1, 3'd2, 8'h12);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'h00);
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1'b1, 3'd2, 8'h12);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.in_ready), 32'h08);
        tick();
        chk_out("bp_next", 1'b1, 3'd3, 8'h13);

        // Wrap: move ptr to 7, then only channel 1 valid
        bus.in_valid = 8'h40;
        tick();
        chk_out("wrap_ch6", 1'b1, 3'd6, 8'h16);
        bus.in_valid = 8'h02;
        #1;
        chk("wrap_rdy", 32'(bus.in_ready), 32'h02);
        tick();
        chk_out("wrap_ch1", 1'b1, 3'd1, 8'h11);

        // Idle: valid drops, data/tag held, ptr stays at 2
        bus.in_valid = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("idle%0d", i), 1'b0, 3'd1, 8'h11);
        end
        bus.in_valid = 8'h0A;
        #1;
        chk("idle_ptr_rdy", 32'(bus.in_ready), 32'h08);
        tick();
        chk_out("idle_after", 1'b1, 3'd3, 8'h13);

`ifdef MUX_CHAN_MASK_EN
        // Mask low four channels; ptr is 4
        bus.chan_mask = 8'h0F;
        bus.in_valid  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("mask%0d", i), 1'b1, 3'(4 + (i % 4)), 8'(8'h14 + (i % 4)));
        end
        bus.chan_mask = 8'hFF;
        #1;
        chk("mask_all_rdy", 32'(bus.in_ready), 32'h00);
        tick();
        chk_out("mask_all_drain", 1'b0, 3'd4, 8'h14);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
